// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit seven-segment scan driver.
// Segment codes are active-low in {g,f,e,d,c,b,a} order; anodes are active-low.
package seg7_pkg;

  // Width of the digit slot index (four digits)
  localparam int DIG_W = 2;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern. Codes 10..15 are not
// valid BCD and show a dash so a converter fault is visible on the board.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure lookup, dash for anything outside 0..9
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a four-digit common-anode display.
// A prescaler divides the clock into digit slots; a 2-bit slot index walks
// digits 0..3. Inputs are sampled into shadow registers only at the last
// cycle of slot 3, so each frame shows one coherent value. All outputs are
// registered, so nothing on the pins depends combinationally on an input.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] thousands_i,
  input  logic [3:0] hundreds_i,
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
  input  logic [3:0] dp_i,
  input  logic       lz_blank_i,
  input  logic       en_i,
  output logic [3:0] anode_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       frame_o
);

  localparam int              CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIG_W-1:0] sel_q, sel_d;

  // Shadow copy of the displayed value; index 3 = thousands, 0 = ones
  logic [3:0][3:0]  sh_dig_q, sh_dig_d;
  logic [3:0]       sh_dp_q,  sh_dp_d;
  logic             sh_lz_q,  sh_lz_d;

  // Output registers
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q,   seg_d;
  logic             dp_q,    dp_d;
  logic             frame_q, frame_d;

  logic             tick;
  logic             capture;
  logic             in_blank;
  logic [3:0]       cur_dig;
  logic [6:0]       dec_seg;
  logic [3:0]       lz_kill;

  assign tick    = (cnt_q == CNT_MAX);
  assign capture = tick && (sel_q == DIG_W'(3));

  // Signed 32-bit compare keeps BLANK_CYCLES=0 well defined (never blank)
  assign in_blank = (int'(cnt_q) < BLANK_CYCLES);

  assign cur_dig = sh_dig_q[sel_q];

  seg7_decode u_decode (
    .bcd_i (cur_dig),
    .seg_o (dec_seg)
  );

  // Leading-zero chain: a digit is blanked only if it and every digit to
  // its left are zero. The ones digit always shows so "0" stays visible.
  always_comb begin
    lz_kill    = '0;
    lz_kill[3] = sh_lz_q && (sh_dig_q[3] == 4'd0);
    lz_kill[2] = lz_kill[3] && (sh_dig_q[2] == 4'd0);
    lz_kill[1] = lz_kill[2] && (sh_dig_q[1] == 4'd0);
    lz_kill[0] = 1'b0;
  end

  // Prescaler and slot index advance
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    sel_d = tick ? sel_q + 1'b1 : sel_q;
  end

  // Shadow registers load only at the frame boundary
  always_comb begin
    sh_dig_d = sh_dig_q;
    sh_dp_d  = sh_dp_q;
    sh_lz_d  = sh_lz_q;
    if (capture) begin
      sh_dig_d = {thousands_i, hundreds_i, tens_i, ones_i};
      sh_dp_d  = dp_i;
      sh_lz_d  = lz_blank_i;
    end
  end

  // Next output values from the current scan position and shadow contents.
  // A blanked leading zero turns off its segments but keeps its dp.
  always_comb begin
    anode_d = ~(4'b0001 << sel_q);
    if (!en_i || in_blank) anode_d = ANODE_OFF;
    seg_d   = lz_kill[sel_q] ? SEG_BLANK : dec_seg;
    dp_d    = ~sh_dp_q[sel_q];
    frame_d = capture;
  end

  // All state, asynchronously cleared; display shows zeros until first capture
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      sel_q    <= '0;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_lz_q  <= 1'b0;
      anode_q  <= ANODE_OFF;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      sh_dig_q <= sh_dig_d;
      sh_dp_q  <= sh_dp_d;
      sh_lz_q  <= sh_lz_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end

  assign anode_o = anode_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, BLANK_CYCLES=1.
// One frame = 16 cycles; each slot = 1 dark cycle + 3 lit cycles on the pins.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] thousands, hundreds, tens, ones, dp;
  logic       lz, en;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dpo, frame;

  int checks   = 0;
  int failures = 0;

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .thousands_i (thousands),
    .hundreds_i  (hundreds),
    .tens_i      (tens),
    .ones_i      (ones),
    .dp_i        (dp),
    .lz_blank_i  (lz),
    .en_i        (en),
    .anode_o     (anode),
    .seg_o       (seg),
    .dp_o        (dpo),
    .frame_o     (frame)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_anode"}, {3'b000, anode}, 7'b0001111);
    chk({tag, "_seg"},   seg,             7'b1111111);
    chk({tag, "_dp"},    {6'd0, dpo},     7'd1);
    chk({tag, "_frame"}, {6'd0, frame},   7'd0);
  endtask

  task automatic set_dig(input logic [3:0] t, h, e, o);
    thousands = t; hundreds = h; tens = e; ones = o;
  endtask

  // Step until frame_o is seen high, leaving us in the cycle of the pulse
  task automatic wait_frame(input string tag);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (frame === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $error("FAIL %s frame_timeout got=no_pulse exp=pulse", tag);
    end
  endtask

  // Check cycles k0..k1 of a frame, counted from the frame_o pulse cycle.
  // s0..s3 are the expected patterns per digit; dpx is the expected dp_o per slot.
  task automatic span(input int k0, input int k1,
                      input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3,
                      input logic [3:0] dpx, input logic en_x, input string tag);
    logic [1:0] slot;
    logic [3:0] ea;
    logic [6:0] es;
    for (int k = k0; k <= k1; k++) begin
      step();
      slot = 2'(k / 4);
      ea   = ((k % 4) == 0 || !en_x) ? 4'b1111 : ~(4'b0001 << slot);
      case (slot)
        2'd0:    es = s0;
        2'd1:    es = s1;
        2'd2:    es = s2;
        default: es = s3;
      endcase
      chk($sformatf("%s_anode_k%0d", tag, k), {3'b000, anode}, {3'b000, ea});
      if (ea != 4'b1111)
        chk($sformatf("%s_seg_k%0d", tag, k), seg, es);
      chk($sformatf("%s_dp_k%0d", tag, k), {6'd0, dpo}, {6'd0, dpx[slot]});
      chk($sformatf("%s_frame_k%0d", tag, k), {6'd0, frame}, {6'd0, (k == 15)});
    end
  endtask

  initial begin
    // Reset held while inputs wiggle
    rst_n = 1'b0; en = 1'b1; lz = 1'b0; dp = 4'b0000;
    set_dig(4'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      set_dig(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      dp = 4'($urandom_range(0, 15));
      lz = 1'($urandom_range(0, 1));
      step();
      chk_reset("rst_hold");
    end
    lz = 1'b0; dp = 4'b0000;
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rel_dark", {3'b000, anode}, 7'b0001111);
    step();
    chk("rel_anode", {3'b000, anode}, 7'b0001110);
    chk("rel_seg",   seg,             7'b1000000);

    // Scan order with 1234
    set_dig(4'd1, 4'd2, 4'd3, 4'd4);
    wait_frame("scan");
    span(0, 15, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111, 1'b1, "scan");

    // Tear-free: change to 5678 while sel==1
    span(0, 5, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111, 1'b1, "tear_a");
    set_dig(4'd5, 4'd6, 4'd7, 4'd8);
    span(6, 15, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111, 1'b1, "tear_b");
    span(0, 15, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010, 4'b1111, 1'b1, "tear_new");

    // Leading-zero suppression, dp on a blanked digit still shown
    set_dig(4'd0, 4'd0, 4'd4, 4'd0); lz = 1'b1; dp = 4'b1000;
    wait_frame("lz1");
    span(0, 15, 7'b1000000, 7'b0011001, 7'b1111111, 7'b1111111, 4'b0111, 1'b1, "lz1");
    lz = 1'b0; dp = 4'b0000;
    wait_frame("lz0");
    span(0, 15, 7'b1000000, 7'b0011001, 7'b1000000, 7'b1000000, 4'b1111, 1'b1, "lz0");

    // Invalid BCD dash and dp on digit 1
    set_dig(4'd1, 4'd2, 4'hC, 4'd4); dp = 4'b0010;
    wait_frame("inv");
    span(0, 15, 7'b0011001, 7'b0111111, 7'b0100100, 7'b1111001, 4'b1101, 1'b1, "inv");

    // Display off for a frame, scan and frame pulses continue
    en = 1'b0;
    span(0, 15, 7'b0011001, 7'b0111111, 7'b0100100, 7'b1111001, 4'b1101, 1'b0, "en0");
    en = 1'b1;
    span(0, 15, 7'b0011001, 7'b0111111, 7'b0100100, 7'b1111001, 4'b1101, 1'b1, "en1");

    // Async reset mid-slot, between clock edges
    span(0, 5, 7'b0011001, 7'b0111111, 7'b0100100, 7'b1111001, 4'b1101, 1'b1, "pre_arst");
    #2 rst_n = 1'b0;
    #1 chk_reset("arst");
    step();
    chk_reset("arst_hold");
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rel2_dark", {3'b000, anode}, 7'b0001111);
    step();
    chk("rel2_anode", {3'b000, anode}, 7'b0001110);
    chk("rel2_seg",   seg,             7'b1000000);
    chk("rel2_dp",    {6'd0, dpo},     7'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for the board's four-digit, common-anode seven-segment display. It consumes the four BCD digits produced by the binary-to-BCD converter (thousands, hundreds, tens, ones) and scans one digit per refresh slot. It captures the digits only at frame boundaries so a display never mixes two values. It also provides ghost blanking between slots, optional leading-zero suppression and per-digit decimal points.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz -> 1 kHz per digit); legal range >= 2
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 .. REFRESH_DIV-1

Ports:
clk_i  in  1  system clock, single clock domain
rst_n_i  in  1  reset, asynchronous, active-low
thousands_i  in  4  BCD digit 3 (leftmost)
hundreds_i  in  4  BCD digit 2
tens_i  in  4  BCD digit 1
ones_i  in  4  BCD digit 0 (rightmost)
dp_i  in  4  decimal-point request per digit, bit n = digit n, active-high
lz_blank_i  in  1  1 = suppress leading zeros
en_i  in  1  1 = display on; 0 = all anodes off (scan keeps running)
anode_o  out  4  digit enables, active-low, bit n = digit n
seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low
dp_o  out  1  decimal point, active-low
frame_o  out  1  one-cycle pulse, high in the cycle after a new shadow capture

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - cnt=0, sel=0, shadow digits=0, shadow dp=0, shadow lz=0.
  - anode_o=4'b1111, seg_o=7'b1111111, dp_o=1, frame_o=0.
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps to 0. tick = (cnt==REFRESH_DIV-1).
- Slot index sel (0..3) increments on tick and wraps 3->0. No other state exists.
- Shadow capture: in the tick cycle with sel==3, all digit, dp and lz inputs are loaded into shadow registers. frame_o=1 in the following cycle only. Inputs are ignored at all other times.
- Digit decode of the shadow digit at index sel (combinational):
  - 0-9 use the standard active-low codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 10-15 (invalid BCD) display a dash: 0111111.
- Leading-zero suppression (shadow lz=1):
  - Digit 3 is blanked if it is 0.
  - Digit 2 is blanked if digits 3 and 2 are both 0.
  - Digit 1 is blanked if digits 3, 2 and 1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives seg=1111111, but its dp is still honoured.
- Anode selection: anode_next = ~(4'b0001<<sel). It is forced to 4'b1111 when en_i=0 or cnt<BLANK_CYCLES.
- Output registers: anode_o, seg_o and dp_o are registered. They reflect the cnt, sel and shadow values of the previous cycle (1-cycle latency). No combinational path exists from any input to any output.
- Boundary behaviour:
  - With BLANK_CYCLES=0, no blank gap exists.
  - en_i toggling takes effect on the next clock edge and never resets cnt or sel.
  - Reset mid-frame discards the partial frame. The display shows zeros until the first capture.
  - Inputs changing in the capture cycle: the value present at that clock edge is captured.

Decomposition:
- Package seg7_pkg holds:
  - localparams SEG_0..SEG_9, SEG_DASH=7'b0111111, SEG_BLANK=7'b1111111, ANODE_OFF=4'b1111;
  - the digit-index width constant (2).
- One combinational sub-module, seg7_decode (4-bit BCD in, 7-bit active-low segments out), instantiated once in the output path.
- Prescaler, slot counter, shadow registers and output registers stay in the top module.

Test Plan:
All scenarios use REFRESH_DIV=4, BLANK_CYCLES=1.
1. Reset: hold rst_n_i=0 while toggling inputs -> anode_o=1111, seg_o=1111111, dp_o=1, frame_o=0. Release -> first lit slot shows anode_o=1110, seg_o=1000000.
2. Scan order: inputs 1,2,3,4 held through a capture, then one full frame observed:
   - anode 1110 with seg 0011001 (4), 1101 with 0110000 (3), 1011 with 0100100 (2), 0111 with 1111001 (1);
   - exactly 1 all-off cycle at the start of each slot;
   - frame_o pulses every 16 cycles.
3. Tear-free capture: change the inputs from 1234 to 5678 during sel==1 -> the remainder of that frame still shows 1234; the next frame shows 5678, starting 1 cycle after the frame_o pulse.
4. Leading zeros: digits 0,0,4,0 with lz_blank_i=1 -> digits 3 and 2 blank (1111111), digit 1 shows 0011001, digit 0 shows 1000000. With lz_blank_i=0, all four digits are lit.
5. Invalid BCD and dp: tens_i=4'hC, dp_i=0010 -> digit 1 shows 0111111 with dp_o=0; every other slot has dp_o=1.
6. Enable and async reset: en_i=0 for one full frame -> anode_o=1111 throughout and frame_o keeps pulsing. Assert rst_n_i mid-slot between clock edges -> outputs go to reset values immediately, without waiting for a clock.
